// File: rtl/polyvecl_pointwise_acc_montgomery_pkg.sv
// Shared constants and FSM encoding for the pointwise Montgomery inner-product stage.
// Optional build macro: POLYVECL_ACC_FREEZE_EN (freezes write-back into [0,Q)).
package polyvecl_pointwise_acc_montgomery_pkg;

  localparam int N_COEFF = 256;
  localparam int COEFF_W = 32;
  localparam int POLY_W  = 8192;

  localparam logic signed [31:0] Q    = 32'sd8380417;
  localparam logic        [31:0] QINV = 32'd58728449;
  localparam logic signed [31:0] MONT = 32'sd4193792;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/polyvecl_pointwise_acc_montgomery_mul_pipe.sv
// One lane: registered 3-stage signed Montgomery product r = a*b*2^-32 mod Q, |r| < Q.
module montgomery_mul_pipe
  import polyvecl_pointwise_acc_montgomery_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_vld,
  input  logic signed [31:0] i_a,
  input  logic signed [31:0] i_b,
  output logic               o_vld,
  output logic signed [31:0] o_r
);

  logic signed [63:0] r_p_p1;
  logic signed [63:0] r_p_p2;
  logic signed [31:0] r_t_p2;
  logic signed [31:0] r_r_p3;
  logic               r_vld_p1;
  logic               r_vld_p2;
  logic               r_vld_p3;

  logic        [31:0] w_t_lo;
  logic signed [63:0] w_tq;
  logic signed [63:0] w_diff;

  // Only the low 32 bits of the product matter for t, so an unsigned multiply is enough.
  assign w_t_lo = r_p_p1[31:0] * QINV;
  assign w_tq   = 64'(r_t_p2) * 64'(Q);
  assign w_diff = r_p_p2 - w_tq;

  // Three product stages: full product, Montgomery quotient, reduced high half.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_p_p1   <= '0;
      r_p_p2   <= '0;
      r_t_p2   <= '0;
      r_r_p3   <= '0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_vld_p3 <= 1'b0;
    end else begin
      r_p_p1   <= 64'(i_a) * 64'(i_b);
      r_vld_p1 <= i_vld;
      r_p_p2   <= r_p_p1;
      r_t_p2   <= w_t_lo;
      r_vld_p2 <= r_vld_p1;
      r_r_p3   <= w_diff[63:32];
      r_vld_p3 <= r_vld_p2;
    end
  end

  assign o_vld = r_vld_p3;
  assign o_r   = r_r_p3;

endmodule

// File: rtl/polyvecl_pointwise_acc_montgomery.sv
// Sequential inner product w = sum_i mont(u[i] o v[i]) using LANES time-shared multipliers.
// Optional build macro: POLYVECL_ACC_FREEZE_EN adds a reduce32+caddq write-back stage.
module polyvecl_pointwise_acc_montgomery
  import polyvecl_pointwise_acc_montgomery_pkg::*;
#(
  parameter int L     = 5,
  parameter int LANES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [L*POLY_W-1:0]   u_in,
  input  logic [L*POLY_W-1:0]   v_in,
  output logic                  busy,
  output logic                  done,
  output logic [POLY_W-1:0]     w_out
);

  localparam int G = N_COEFF / LANES;
`ifdef POLYVECL_ACC_FREEZE_EN
  localparam int DRAIN_CYC = 4;
`else
  localparam int DRAIN_CYC = 3;
`endif

  state_t             r_state;
  state_t             w_next;
  logic [7:0]         r_g;
  logic [7:0]         r_i;
  logic [2:0]         r_dcnt;
  logic               w_issue;
  logic               w_last_beat;
  logic [31:0]        w_base;

  logic [7:0]         r_i_p1, r_i_p2, r_i_p3;
  logic [7:0]         r_g_p1, r_g_p2, r_g_p3;
  logic [LANES-1:0]   w_vld;
  logic               w_vld_p3;
  logic signed [31:0] w_a   [LANES];
  logic signed [31:0] w_b   [LANES];
  logic signed [31:0] w_r   [LANES];
  logic signed [31:0] w_sum [LANES];
  logic signed [31:0] r_acc [LANES];

  assign w_last_beat = (r_g == 8'(G - 1)) && (r_i == 8'(L - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_RUN;
      ST_RUN:   if (w_last_beat) w_next = ST_DRAIN;
      ST_DRAIN: if (r_dcnt == 3'(DRAIN_CYC - 1)) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    done    = (r_state == ST_DONE);
    w_issue = (r_state == ST_RUN);
  end

  // Beat counters: poly index i inner, coefficient group g outer; drain cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_g    <= '0;
      r_i    <= '0;
      r_dcnt <= '0;
    end else begin
      if (r_state == ST_RUN) begin
        if (r_i == 8'(L - 1)) begin
          r_i <= '0;
          r_g <= r_g + 8'd1;
        end else begin
          r_i <= r_i + 8'd1;
        end
      end else begin
        r_i <= '0;
        r_g <= '0;
      end
      if (r_state == ST_DRAIN) r_dcnt <= r_dcnt + 3'd1;
      else                     r_dcnt <= '0;
    end
  end

  // Operand mux: bit offset of coefficient g*LANES of poly i.
  assign w_base = 32'(POLY_W) * 32'(r_i) + 32'(COEFF_W * LANES) * 32'(r_g);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_a[l] = u_in[w_base + 32'(l * COEFF_W) +: COEFF_W];
    assign w_b[l] = v_in[w_base + 32'(l * COEFF_W) +: COEFF_W];

    montgomery_mul_pipe u_mul (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_vld   (w_issue),
      .i_a     (w_a[l]),
      .i_b     (w_b[l]),
      .o_vld   (w_vld[l]),
      .o_r     (w_r[l])
    );

    assign w_sum[l] = (r_i_p3 == 8'd0) ? w_r[l] : r_acc[l] + w_r[l];
  end

  assign w_vld_p3 = &w_vld;

  // Beat tags travel alongside the multiplier pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_p1 <= '0; r_i_p2 <= '0; r_i_p3 <= '0;
      r_g_p1 <= '0; r_g_p2 <= '0; r_g_p3 <= '0;
    end else begin
      r_i_p1 <= r_i;    r_g_p1 <= r_g;
      r_i_p2 <= r_i_p1; r_g_p2 <= r_g_p1;
      r_i_p3 <= r_i_p2; r_g_p3 <= r_g_p2;
    end
  end

`ifdef POLYVECL_ACC_FREEZE_EN
  logic               r_fz_vld_p4;
  logic [7:0]         r_fz_g_p4;
  logic signed [31:0] r_fz_val_p4 [LANES];

  function automatic logic signed [31:0] reduce32(input logic signed [31:0] a);
    logic signed [31:0] t;
    t = (a + 32'sd4194304) >>> 23;
    return a - t * Q;
  endfunction

  function automatic logic signed [31:0] caddq(input logic signed [31:0] a);
    return a[31] ? a + Q : a;
  endfunction

  // Accumulate, stage the finished sum, then write the frozen value one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fz_vld_p4 <= 1'b0;
      r_fz_g_p4   <= '0;
      w_out       <= '0;
      for (int l = 0; l < LANES; l++) begin
        r_acc[l]       <= '0;
        r_fz_val_p4[l] <= '0;
      end
    end else begin
      r_fz_vld_p4 <= w_vld_p3 && (r_i_p3 == 8'(L - 1));
      r_fz_g_p4   <= r_g_p3;
      for (int l = 0; l < LANES; l++) begin
        if (w_vld_p3) r_acc[l] <= w_sum[l];
        r_fz_val_p4[l] <= w_sum[l];
        if (r_fz_vld_p4)
          w_out[(int'(r_fz_g_p4) * LANES + l) * COEFF_W +: COEFF_W] <= caddq(reduce32(r_fz_val_p4[l]));
      end
    end
  end
`else
  // Accumulate per lane; the last poly of a group writes the raw sum into w_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_out <= '0;
      for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (w_vld_p3) r_acc[l] <= w_sum[l];
        if (w_vld_p3 && (r_i_p3 == 8'(L - 1)))
          w_out[(int'(r_g_p3) * LANES + l) * COEFF_W +: COEFF_W] <= w_sum[l];
      end
    end
  end
`endif

endmodule

// File: tb/tb_polyvecl_pointwise_acc_montgomery.sv
// Self-checking bench for polyvecl_pointwise_acc_montgomery (directed vectors + reference model).
module tb_polyvecl_pointwise_acc_montgomery;

  localparam int L     = 5;
  localparam int LANES = 8;
  localparam int NB    = L * 256 / LANES;
  localparam int Q     = 8380417;
  localparam int QINV  = 58728449;
  localparam int MONT  = 4193792;
`ifdef POLYVECL_ACC_FREEZE_EN
  localparam int DONE_C = NB + 5;
`else
  localparam int DONE_C = NB + 4;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [L*8192-1:0]   u_bits = '0;
  logic [L*8192-1:0]   v_bits = '0;
  logic                busy;
  logic                done;
  logic [8191:0]       w_out;

  int                  u_a [L][256];
  int                  v_a [L][256];
  int                  n_checks = 0;
  int                  n_errors = 0;

  int                  m_c = -1;
  logic [8191:0]       m_exp  = '0;
  logic [8191:0]       m_run  = '0;
  logic [8191:0]       m_wout = '0;

  polyvecl_pointwise_acc_montgomery #(.L(L), .LANES(LANES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .u_in  (u_bits),
    .v_in  (v_bits),
    .busy  (busy),
    .done  (done),
    .w_out (w_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string nm, input logic [8191:0] act, input logic [8191:0] exp);
    int bad;
    int first;
    bad = 0; first = -1;
    for (int j = 0; j < 256; j++)
      if (act[32*j +: 32] !== exp[32*j +: 32]) begin
        bad++;
        if (first < 0) first = j;
      end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL %s coeffs_wrong=%0d first=%0d actual=%0d required=%0d at %0t", nm, bad, first,
               $signed(act[32*first +: 32]), $signed(exp[32*first +: 32]), $time);
    end
  endtask

  // Reference arithmetic straight from the C definition.
  function automatic int mont(input int a, input int b);
    longint p;
    int     t;
    longint r;
    p = longint'(a) * longint'(b);
    t = int'(p) * QINV;
    r = (p - longint'(t) * longint'(Q)) >>> 32;
    return int'(r);
  endfunction

  function automatic int freeze(input int a);
    int t;
    int r;
    t = (a + (1 << 22)) >>> 23;
    r = a - t * Q;
    if (r < 0) r = r + Q;
    return r;
  endfunction

  function automatic logic [8191:0] model_w();
    logic [8191:0] w;
    int acc;
    w = '0;
    for (int j = 0; j < 256; j++) begin
      acc = 0;
      for (int i = 0; i < L; i++) acc = acc + mont(u_a[i][j], v_a[i][j]);
`ifdef POLYVECL_ACC_FREEZE_EN
      acc = freeze(acc);
`endif
      w[32*j +: 32] = acc;
    end
    return w;
  endfunction

  task automatic load();
    for (int i = 0; i < L; i++)
      for (int j = 0; j < 256; j++) begin
        u_bits[8192*i + 32*j +: 32] = u_a[i][j];
        v_bits[8192*i + 32*j +: 32] = v_a[i][j];
      end
    m_exp = model_w();
  endtask

  task automatic fill(input int mode_u, input int mode_v);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < 256; j++) begin
        u_a[i][j] = (mode_u == 0) ? 0 : (mode_u == 1) ? MONT : int'($urandom_range(0, 2*Q-2)) - (Q-1);
        v_a[i][j] = (mode_v == 0) ? 0 : (mode_v == 1) ? 1 : (mode_v == 2) ? -1
                                  : int'($urandom_range(0, 2*Q-2)) - (Q-1);
      end
    load();
  endtask

  // Waits from cycle 1 of a run until done; returns the cycle number done appeared in.
  task automatic wait_done(input int mid_start, output int cyc);
    cyc = 1;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == mid_start);
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic run_once(input int mid_start, output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(mid_start, cyc);
    #1;
  endtask

  // Control/result model: cycle index since start accept, driven by the protocol rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_c    <= -1;
      m_wout <= '0;
    end else if (m_c < 0) begin
      if (start) begin
        m_c   <= 1;
        m_run <= m_exp;
      end
    end else if (m_c == DONE_C) begin
      m_c    <= -1;
      m_wout <= m_run;
    end else begin
      m_c <= m_c + 1;
    end
  end

  // Compare DUT outputs against the model on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_c < 0) begin
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk_w("idle_w_hold", w_out, m_wout);
      end else begin
        chk("run_busy", busy, (m_c < DONE_C));
        chk("run_done", done, (m_c == DONE_C));
        if (m_c == DONE_C) chk_w("w_result", w_out, m_run);
      end
    end
  end

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_w0", $signed(w_out[31:0]), 0);
    #2 rst_n = 1'b1;

    // u = MONT, v = 1: every coefficient is L.
    fill(1, 1);
`ifdef POLYVECL_ACC_FREEZE_EN
    chk("model_pin_5", $signed(m_exp[31:0]), 5);
`else
    chk("model_pin_5", $signed(m_exp[31:0]), 5);
`endif
    run_once(0, cyc);
`ifdef POLYVECL_ACC_FREEZE_EN
    chk("latency", cyc, 165);
`else
    chk("latency", cyc, 164);
`endif
    chk("w_mont_one_c0", $signed(w_out[31:0]), 5);
    chk("w_mont_one_c255", $signed(w_out[8191:8160]), 5);

    // u = MONT, v = -1, started on the cycle right after done.
    fill(1, 2);
`ifdef POLYVECL_ACC_FREEZE_EN
    chk("model_pin_m5", $signed(m_exp[31:0]), 8380412);
`else
    chk("model_pin_m5", $signed(m_exp[31:0]), -5);
`endif
    run_once(0, cyc);
`ifdef POLYVECL_ACC_FREEZE_EN
    chk("w_mont_neg_c100", $signed(w_out[32*100 +: 32]), 8380412);
`else
    chk("w_mont_neg_c100", $signed(w_out[32*100 +: 32]), -5);
`endif

    // u all zero with random v; a second start mid-run must be ignored.
    fill(0, 3);
    run_once(40, cyc);
    chk("w_zero_c7", $signed(w_out[32*7 +: 32]), 0);
    chk("w_zero_c200", $signed(w_out[32*200 +: 32]), 0);

    // Random operands, twice back to back.
    fill(3, 3);
    run_once(0, cyc);
    fill(3, 3);
    run_once(0, cyc);

    // start raised during DONE is ignored and then accepted the following cycle.
    @(negedge clk);
    start = 1'b1;
    wait (done);
    @(negedge clk);
    #1;
    fill(3, 0);
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(0, cyc);
    #1;

    // Asynchronous reset in the middle of RUN, then a fresh full run.
    fill(3, 3);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (70) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_w_c0", $signed(w_out[31:0]), 0);
    chk("rst_mid_w_c255", $signed(w_out[8191:8160]), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    fill(3, 3);
    run_once(0, cyc);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
